// File: rtl/sprite_channel_mux_if.sv
// Handshake bundle between the sprite channel generators, the channel mux and the pixel compositor.
interface sprite_channel_mux_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 16
);
  localparam int unsigned CW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS-1:0]       select;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      err_clear;
  logic                      multi_hot_err;

  modport master (
    output in_data, in_valid, select, out_ready, err_clear,
    input  in_ready, out_data, out_chan, out_valid, multi_hot_err
  );

  modport slave (
    input  in_data, in_valid, select, out_ready, err_clear,
    output in_ready, out_data, out_chan, out_valid, multi_hot_err
  );
endinterface

// File: rtl/sprite_channel_mux.sv
// N-channel sprite mux: picks one eligible channel per transfer (one-hot OR, fixed
// priority or round-robin) and registers it into a single backpressured output stage.
module sprite_channel_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned MODE     = 0
) (
  input logic                 clk,
  input logic                 reset,
  sprite_channel_mux_if.slave bus
);
  localparam int unsigned CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] grant;
  logic                load;
  logic                multi;
  logic                rr_found;
  logic [WIDTH-1:0]    win_data;
  logic [CW-1:0]       win_chan;
  logic [CW-1:0]       rr_ptr;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [CW-1:0]       out_chan_q;
  logic                err_q;

  // Load gated by reset so no channel is ever acknowledged while the stage is being cleared.
  assign eligible = bus.in_valid & bus.select;
  assign load     = (|eligible) & (~out_valid_q | bus.out_ready) & ~reset;
  assign multi    = (eligible & (eligible - CHANNELS'(1))) != '0;

  // Winner selection for the configured arbitration mode
  always_comb begin
    grant    = '0;
    win_chan = '0;
    rr_found = 1'b0;
    if (MODE == 0) begin
      grant = eligible;
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (eligible[i]) win_chan = CW'(i);
      end
    end else if (MODE == 1) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (eligible[i]) win_chan = CW'(i);
      end
      grant[win_chan] = |eligible;
    end else begin
      for (int k = 1; k <= int'(CHANNELS); k++) begin
        if (!rr_found && eligible[CW'((int'(rr_ptr) + k) % int'(CHANNELS))]) begin
          rr_found = 1'b1;
          win_chan = CW'((int'(rr_ptr) + k) % int'(CHANNELS));
        end
      end
      grant[win_chan] = rr_found;
    end
  end

  // Granted channels are ORed; in the one-hot-OR mode this is the legacy merge.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant[i]) win_data = win_data | bus.in_data[i*int'(WIDTH) +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      err_q       <= 1'b0;
      rr_ptr      <= CW'(CHANNELS - 1);
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_chan_q  <= win_chan;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (MODE == 2 && load) rr_ptr <= win_chan;
      if (MODE == 0 && load && multi) err_q <= 1'b1;
      else if (bus.err_clear)         err_q <= 1'b0;
    end
  end

  assign bus.in_ready      = load ? grant : '0;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_chan      = out_chan_q;
  assign bus.multi_hot_err = err_q;
endmodule

// File: doc/sprite_channel_mux.md
# sprite_channel_mux

Registered, parameterised N-channel by W-bit sprite channel multiplexer with per-channel valid/ready handshakes. It is the generalised successor of the fixed 16-channel, 32-bit one-hot select mux. The block selects one eligible sprite channel per transfer in one of three modes: legacy one-hot OR, fixed priority, or round-robin. It registers the winner into a single output stage with backpressure, and it sits between the sprite channel generators and the pixel compositor.

## Interface
Parameters:
- WIDTH, 32, data bits per channel (>=1)
- CHANNELS, 16, number of input channels (>=2)
- MODE, 0, arbitration mode: 0 = one-hot OR, 1 = fixed priority (highest index wins), 2 = round-robin

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i is bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i is offering data
- in_ready  output  CHANNELS  channel i's data is consumed this cycle (combinational)
- select  input  CHANNELS  enable mask; channel i is eligible only when in_valid[i] & select[i]
- out_data  output  WIDTH  registered selected data
- out_chan  output  $clog2(CHANNELS)  registered index of the winning channel
- out_valid  output  1  output register holds data
- out_ready  input  1  downstream accepts out_data this cycle
- err_clear  input  1  clears multi_hot_err
- multi_hot_err  output  1  sticky flag: MODE 0 saw more than one eligible channel on a load

## Operation
- eligible = in_valid & select.
- load = (|eligible) & (~out_valid | out_ready). The output register accepts new data only on load.
- Grant vector (one-hot except in MODE 0):
  - MODE 0: grant = eligible. out_data = bitwise OR of all eligible channels (legacy behaviour). out_chan = lowest eligible index. If more than one channel is eligible on a load, multi_hot_err is set.
  - MODE 1: grant = the highest eligible index.
  - MODE 2: rr_ptr holds the last granted index. The search starts at rr_ptr+1 and wraps modulo CHANNELS; the first eligible channel wins. rr_ptr updates to the winner only on load.
- in_ready[i] = load & grant[i]. No channel sees in_ready without in_valid & select.
- Output register:
  - load: register winner data/index and set out_valid=1.
  - else if out_ready: clear out_valid.
  - else: hold.
- Held out_data/out_chan stay stable while out_valid=1 and out_ready=0.
- multi_hot_err set and clear:
  - set has priority over err_clear in the same cycle.
  - err_clear alone drives it to 0 next cycle.
  - The flag is never set outside MODE 0.
- Changes to select or in_valid while stalled do not affect the already registered output.

## Timing
- Reset (asynchronous, immediate) drives the following values:
  - out_valid=0, out_data=0, out_chan=0, multi_hot_err=0
  - rr_ptr=CHANNELS-1, so channel 0 wins first in MODE 2
- After reset, in_ready is 0 until an eligible channel exists.
- Latency is 1 cycle from the load edge to out_valid/out_data.
- Throughput is one transfer per cycle when out_ready is held 1.
- Full throughput holds with a simultaneous load and drain in the same cycle: the new data replaces the old, and out_valid stays 1.
- Reset asserted mid-transfer discards the registered word. No in_ready is asserted during reset.
- No eligible channel with out_ready=1: out_valid falls next cycle. No eligible channel with out_ready=0: the register holds.
- Wrap-around: in MODE 2 with rr_ptr=CHANNELS-1, the search begins at channel 0.

## Test plan
- MODE 1, WIDTH=32, CHANNELS=16, out_ready=1. Drive channels 3 and 12 valid and selected with data 0x0000_0003 and 0x0000_000C. Required: in_ready=0x1000; the next cycle gives out_data=0x0000_000C, out_chan=12, out_valid=1.
- MODE 0. Drive only channel 5 eligible with 0xA5A5_0000, then channels 1 and 2 eligible with 0x0F and 0xF0. Required: first out_data=0xA5A5_0000 with out_chan=5 and err=0. Second out_data=0xFF with out_chan=1 and multi_hot_err=1. Asserting err_clear alone then gives err=0 next cycle.
- MODE 2. Hold all 16 channels valid and selected, with out_ready=1 for 18 cycles. Required: out_chan sequence 0,1,…,15,0,1; exactly one in_ready bit per cycle.
- Backpressure. Load channel 7 (0x1234_5678), then hold out_ready=0 for 4 cycles while channel 9 stays eligible. Required: out_data stays 0x1234_5678 and out_chan stays 7, with in_ready=0. On the first cycle out_ready=1, in_ready[9]=1, and the next cycle gives out_chan=9.
- Select masking. Drive in_valid=0xFFFF with select=0x0000, then select=0x0100 in MODE 2. Required: no in_ready and out_valid=0 while the mask is zero. Then out_chan=8, in_ready=0x0100.
- Reset mid-operation. Assert reset asynchronously with out_valid=1 and rr_ptr=4. Required: out_valid=0, out_data=0, and multi_hot_err=0 immediately. After release with all channels eligible, channel 0 wins first.
